// File: rtl/regfile_2r1w_clr.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional write-to-read bypass, optional hardwired-zero entry 0
// and a sequential bulk-clear engine that sweeps one entry per cycle.
//
// Handshake: a write is taken on a rising clk edge when we=1 and wr_ready=1
// (and reset=0); wr_ready only drops while the clear engine is sweeping, and a
// write presented while wr_ready=0 is discarded, never held or queued.
module regfile_2r1w_clr #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic             wr_ready,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_start,
    output logic             busy,
    output logic             clr_done
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic waddr_ok;
    logic raddr_a_ok;
    logic raddr_b_ok;
    logic wr_hit;
    logic wr_ok;
    logic sweep_last;

    // Address qualification: out-of-range addresses and (optionally) entry 0
    // never reach the array.
    assign waddr_ok   = ({1'b0, waddr} < DEPTH_W) && !((ZERO_REG != 0) && (waddr == '0));
    assign raddr_a_ok = ({1'b0, raddr_a} < DEPTH_W) && !((ZERO_REG != 0) && (raddr_a == '0));
    assign raddr_b_ok = ({1'b0, raddr_b} < DEPTH_W) && !((ZERO_REG != 0) && (raddr_b == '0));

    // wr_hit drives the bypass; the actual array update is additionally
    // suppressed by reset.
    assign wr_hit = we && wr_ready && waddr_ok;
    assign wr_ok  = wr_hit && !reset;

    assign wr_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_CLEAR);
    assign sweep_last = busy && (cnt_q == LAST_IDX);
    // A reset landing on the final sweep cycle aborts it, so no pulse then.
    assign clr_done   = sweep_last && !reset;

    // Clear engine next-state: IDLE waits for clr_start, CLEAR walks the
    // counter from 0 to DEPTH-1 and returns to IDLE after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Array next-state: reset wipes everything, the sweep zeroes one entry,
    // otherwise an accepted write lands (writes are blocked while sweeping).
    always_comb begin
        mem_d = mem_q;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (busy) begin
            mem_d[cnt_q] = '0;
        end else if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read ports: zero for unmapped addresses, optional bypass of the write
    // in flight, otherwise the stored contents.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a_ok) begin
            if ((BYPASS != 0) && wr_hit && (waddr == raddr_a)) begin
                rdata_a = wdata;
            end else begin
                rdata_a = mem_q[raddr_a];
            end
        end
        if (raddr_b_ok) begin
            if ((BYPASS != 0) && wr_hit && (waddr == raddr_b)) begin
                rdata_b = wdata;
            end else begin
                rdata_b = mem_q[raddr_b];
            end
        end
    end

    // State registers; reset is folded into the _d logic above.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        mem_q   <= mem_d;
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Bench for regfile_2r1w_clr: three instances (plain 8-entry, bypass plus
// zero-register 8-entry, plain 6-entry) share one input stimulus; a reference
// model predicts every output each cycle and a queue scoreboard compares.
module tb_regfile_2r1w_clr;

  localparam int W = 8;
  localparam int N = 3;

  logic         clk;
  logic         reset;
  logic         we;
  logic [2:0]   waddr;
  logic [W-1:0] wdata;
  logic [2:0]   raddr_a;
  logic [2:0]   raddr_b;
  logic         clr_start;

  logic [W-1:0] rd_a [N];
  logic [W-1:0] rd_b [N];
  logic         busy_o [N];
  logic         wrr_o [N];
  logic         done_o [N];

  int cfg_depth [N] = '{8, 8, 6};
  int cfg_byp   [N] = '{0, 1, 0};
  int cfg_zr    [N] = '{0, 1, 0};

  // reference model state
  logic [W-1:0] m_mem [N][8];
  bit           m_busy [N];
  int           m_cnt [N];

  // scoreboard
  logic [W-1:0] exp_q [$];
  string        tag_q [$];

  int  n_chk;
  int  n_pass;
  bit  chk_en;
  int  nb [N];
  int  nd [N];

  regfile_2r1w_clr #(.WIDTH(8), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) u_base (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wrr_o[0]), .raddr_a(raddr_a), .rdata_a(rd_a[0]),
    .raddr_b(raddr_b), .rdata_b(rd_b[0]), .clr_start(clr_start),
    .busy(busy_o[0]), .clr_done(done_o[0])
  );

  regfile_2r1w_clr #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) u_bz (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wrr_o[1]), .raddr_a(raddr_a), .rdata_a(rd_a[1]),
    .raddr_b(raddr_b), .rdata_b(rd_b[1]), .clr_start(clr_start),
    .busy(busy_o[1]), .clr_done(done_o[1])
  );

  regfile_2r1w_clr #(.WIDTH(8), .DEPTH(6), .BYPASS(0), .ZERO_REG(0)) u_d6 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wrr_o[2]), .raddr_a(raddr_a), .rdata_a(rd_a[2]),
    .raddr_b(raddr_b), .rdata_b(rd_b[2]), .clr_start(clr_start),
    .busy(busy_o[2]), .clr_done(done_o[2])
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input int k, input logic [2:0] ra);
    if (int'(ra) >= cfg_depth[k]) return '0;
    if (cfg_zr[k] != 0 && ra == 3'd0) return '0;
    if (cfg_byp[k] != 0 && we && !m_busy[k] && waddr == ra &&
        int'(waddr) < cfg_depth[k] && !(cfg_zr[k] != 0 && waddr == 3'd0))
      return wdata;
    return m_mem[k][ra];
  endfunction

  function automatic logic exp_done(input int k);
    return m_busy[k] && (m_cnt[k] == cfg_depth[k] - 1) && !reset;
  endfunction

  // advance the model by one rising edge using the currently driven inputs
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
        m_busy[k] = 1'b0;
        m_cnt[k]  = 0;
      end else if (m_busy[k]) begin
        m_mem[k][m_cnt[k]] = '0;
        if (m_cnt[k] == cfg_depth[k] - 1) begin
          m_busy[k] = 1'b0;
          m_cnt[k]  = 0;
        end else begin
          m_cnt[k]++;
        end
      end else begin
        if (we && int'(waddr) < cfg_depth[k] && !(cfg_zr[k] != 0 && waddr == 3'd0))
          m_mem[k][waddr] = wdata;
        if (clr_start) begin
          m_busy[k] = 1'b1;
          m_cnt[k]  = 0;
        end
      end
    end
  endtask

  // one clock cycle: queue expectations for the driven inputs, compare the
  // DUT outputs against them, then take the edge
  task automatic tick();
    logic [W-1:0] act [$];
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(exp_rd(k, raddr_a));  tag_q.push_back($sformatf("rdata_a[%0d]", k));
      exp_q.push_back(exp_rd(k, raddr_b));  tag_q.push_back($sformatf("rdata_b[%0d]", k));
      exp_q.push_back({7'd0, m_busy[k]});   tag_q.push_back($sformatf("busy[%0d]", k));
      exp_q.push_back({7'd0, !m_busy[k]});  tag_q.push_back($sformatf("wr_ready[%0d]", k));
      exp_q.push_back({7'd0, exp_done(k)}); tag_q.push_back($sformatf("clr_done[%0d]", k));
    end
    #1;
    for (int k = 0; k < N; k++) begin
      act.push_back(rd_a[k]);
      act.push_back(rd_b[k]);
      act.push_back({7'd0, busy_o[k]});
      act.push_back({7'd0, wrr_o[k]});
      act.push_back({7'd0, done_o[k]});
    end
    while (exp_q.size() > 0) begin
      if (chk_en) check(tag_q[0], act[0], exp_q[0]);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
      void'(act.pop_front());
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(7 - a);
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; chk_en = 1'b0;
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 1'b0; m_cnt[k] = 0;
      for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
    end

    // reset: first cycle unchecked (contents unknown), second checked
    tick();
    chk_en = 1'b1;
    we = 1'b1; waddr = 3'd4; wdata = 8'hC3; clr_start = 1'b1;
    tick();
    we = 1'b0; clr_start = 1'b0; reset = 1'b0;
    read_all();

    // write then read on both ports
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h5A);
    raddr_a = 3'd3; raddr_b = 3'd7;
    #1;
    check("t1_rd_a", rd_a[0], 8'hA5);
    check("t1_rd_b", rd_b[0], 8'h5A);
    tick();
    raddr_b = 3'd3;
    #1;
    check("t1_same_a", rd_a[0], 8'hA5);
    check("t1_same_b", rd_b[0], 8'hA5);
    tick();

    // bypass vs registered read
    we = 1'b1; waddr = 3'd2; wdata = 8'h3C; raddr_a = 3'd2;
    #1;
    check("t2_bypass", rd_a[1], 8'h3C);
    check("t2_no_bypass", rd_a[0], 8'h00);
    tick();
    we = 1'b0;
    #1;
    check("t2_next_cycle", rd_a[0], 8'h3C);
    tick();

    // hardwired zero entry, including the write cycle with bypass on
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0;
    #1;
    check("t3_zero_wcyc", rd_a[1], 8'h00);
    tick();
    we = 1'b0;
    #1;
    check("t3_zero_after", rd_a[1], 8'h00);
    check("t3_plain_addr0", rd_a[0], 8'hFF);
    tick();

    // fill, then bulk clear with a dropped write and an ignored restart
    for (int a = 0; a < 8; a++) wr(3'(a), 8'(8'h11 * (a + 1)));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < N; k++) begin nb[k] = 0; nd[k] = 0; end
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) begin
        if (busy_o[k]) nb[k]++;
        if (done_o[k]) nd[k]++;
      end
      if (done_o[0]) check("t4_done_cycle", 8'(i), 8'd7);
      if (i == 2) begin we = 1'b1; waddr = 3'd1; wdata = 8'hEE; end
      if (i == 3) clr_start = 1'b1;
      if (i == 4) begin
        raddr_a = 3'd5; raddr_b = 3'd2;
        #1;
        check("t4_mid_unswept", rd_a[0], 8'h66);
        check("t4_mid_swept", rd_b[0], 8'h00);
      end
      tick();
      we = 1'b0; clr_start = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      check($sformatf("t4_busy_cycles[%0d]", k), 8'(nb[k]), 8'(cfg_depth[k]));
      check($sformatf("t4_done_pulses[%0d]", k), 8'(nd[k]), 8'd1);
    end
    check("t4_wr_ready", {7'd0, wrr_o[0]}, 8'd1);
    read_all();

    // reset in the middle of a sweep
    for (int a = 0; a < 8; a++) wr(3'(a), 8'(8'h21 + a));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < N; k++) nd[k] = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < N; k++) if (done_o[k]) nd[k]++;
      if (i == 1) clr_start = 1'b1;
      if (i == 2) reset = 1'b1;
      tick();
      clr_start = 1'b0;
      if (i == 2) begin
        reset = 1'b0;
        for (int k = 0; k < N; k++)
          check($sformatf("t5_busy_after_reset[%0d]", k), {7'd0, busy_o[k]}, 8'd0);
      end
    end
    for (int k = 0; k < N; k++)
      check($sformatf("t5_no_done[%0d]", k), 8'(nd[k]), 8'd0);
    read_all();

    // six-entry instance: out-of-range write and reads
    wr(3'd6, 8'h77);
    raddr_a = 3'd6; raddr_b = 3'd7;
    #1;
    check("t6_drop_addr6", rd_a[2], 8'h00);
    check("t6_read_addr7", rd_b[2], 8'h00);
    check("t6_base_addr6", rd_a[0], 8'h77);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      we        = $urandom_range(0, 1) == 1;
      waddr     = 3'($urandom_range(0, 7));
      wdata     = 8'($urandom_range(0, 255));
      raddr_a   = 3'($urandom_range(0, 7));
      raddr_b   = 3'($urandom_range(0, 7));
      clr_start = ($urandom_range(0, 15) == 0);
      tick();
    end
    reset = 1'b0; we = 1'b0; clr_start = 1'b0;
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
- Parametrised register file, successor to the fixed 8x8 single-port bank.
- Provides one synchronous write port and two asynchronous read ports.
- Optional write-to-read bypass and an optional hardwired-zero entry 0.
- A sequential bulk-clear engine wipes the array one entry per cycle without asserting reset.
- Used as the general-purpose operand store for datapath blocks.

Parameters:
- WIDTH, 8, data width of each entry in bits (>=1).
- DEPTH, 8, number of entries (>=2, need not be a power of two).
- BYPASS, 0, 1 = a read of the address being written this cycle returns wdata combinationally.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded.
- Localparam AW = $clog2(DEPTH), address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears array and clear engine
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- wr_ready  output  1  high when writes are accepted (engine idle)
- raddr_a  input  AW  read port A address
- rdata_a  output  WIDTH  read port A data, combinational
- raddr_b  input  AW  read port B address
- rdata_b  output  WIDTH  read port B data, combinational
- clr_start  input  1  single-cycle request to start a bulk clear
- busy  output  1  clear engine active
- clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (sampled at a clk edge with reset=1):
  - All DEPTH entries become 0 in that cycle.
  - The FSM goes to IDLE and the clear counter goes to 0.
  - busy=0, clr_done=0, wr_ready=1 from the next cycle on.
  - reset overrides any write or clr_start in the same cycle.
  - Reset mid-clear aborts the sweep; no clr_done pulse is generated.
- Write:
  - When we=1, wr_ready=1, reset=0 and waddr<DEPTH, mem[waddr] <= wdata at the clk edge.
  - Write-to-read latency is 1 cycle without bypass.
  - Writes with waddr>=DEPTH are dropped silently.
  - Writes while wr_ready=0 are dropped; there is no queueing or back-pressure beyond wr_ready.
- Read (both ports independent and combinational):
  - rdata_x = mem[raddr_x].
  - raddr_x>=DEPTH returns 0.
  - ZERO_REG=1 and raddr_x=0 returns 0.
  - BYPASS=1 and (we && wr_ready && waddr==raddr_x && waddr<DEPTH && !(ZERO_REG && waddr==0)) returns wdata.
  - Both ports may read the same address.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE: busy=0, wr_ready=1. clr_start=1 -> CLEAR, counter <= 0. A write in the same cycle as clr_start is accepted.
  - CLEAR: busy=1, wr_ready=0. Each cycle mem[counter] <= 0 and counter increments.
    - When counter==DEPTH-1, that entry is cleared, clr_done pulses high for that single cycle (combinational with the final clear), and the next state is IDLE.
    - A full clear takes exactly DEPTH cycles in CLEAR.
  - clr_start while busy is ignored; it neither restarts nor extends the sweep.
  - Reads during CLEAR return current contents: swept entries read 0, unswept entries keep their old data.
- Widths:
  - Counter width is AW. The compare uses DEPTH-1, so the counter never wraps past DEPTH.
  - No arithmetic on data.

Test Plan:
1. Reset, then write 0xA5 to addr 3 and 0x5A to addr 7; read A=3, B=7 next cycle -> rdata_a=0xA5, rdata_b=0x5A. Both ports at addr 3 -> both 0xA5.
2. BYPASS=1: in the same cycle we=1, waddr=2, wdata=0x3C, raddr_a=2 -> rdata_a=0x3C in that cycle. With BYPASS=0 -> old value (0) in that cycle, 0x3C the next cycle.
3. ZERO_REG=1: write 0xFF to addr 0 -> rdata_a at addr 0 stays 0x00, including in the write cycle with BYPASS=1.
4. Fill all 8 entries with 0x11..0x88, pulse clr_start:
   - busy=1 for exactly 8 cycles; clr_done pulses on the 8th.
   - Mid-sweep (after 4 cycles) addr 5 still reads 0x66 and addr 2 reads 0.
   - A write issued during busy is dropped.
   - Afterwards all entries read 0 and wr_ready=1.
5. Start a clear, assert reset on sweep cycle 3 -> busy=0 next cycle, no clr_done, all entries 0. A clr_start issued mid-sweep does not extend busy beyond DEPTH cycles.
6. DEPTH=6 (AW=3): write 0x77 to addr 6 -> dropped; raddr 7 reads 0. Clear takes 6 cycles and clr_done pulses once.
